sha256_round_ctrl: RTL and testbench

Control sequencer for the SHA-256 compression datapath: accepts one 512-bit block per start request, then drives initial-hash load, working-variable load, the 64-round iteration and the final result capture. Sits beside the message-schedule unit, round datapath and result register; it owns no data, only strobes, round index and block count. Its `sel_res256_o` drives the result register, which captures H0..H7 + A..H.

---
 rtl/sha256_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: walks one 512-bit block through IV load,
// working-variable load, ROUNDS iterations, result capture and a done pulse.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64,
  parameter int RIDX_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              first_block_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              init_hash_o,
  output logic              load_work_o,
  output logic              round_en_o,
  output logic [RIDX_W-1:0] round_idx_o,
  output logic              msg_rd_o,
  output logic              w_sel_o,
  output logic              sel_res256_o,
  output logic              update_h_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  blk_cnt_o,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(ROUNDS - 1);
  localparam logic [RIDX_W-1:0] RAW_WORDS  = RIDX_W'(16);

  state_t             state_q, state_d;
  logic [RIDX_W-1:0]  cnt_q, cnt_d;
  logic               first_q, first_d;
  logic [CNT_W-1:0]   blk_q, blk_d;

  // Next-cycle strobes, decoded from the next state so the outputs are
  // registered yet line up with the state they belong to.
  logic               busy_d, init_hash_d, load_work_d, round_en_d;
  logic [RIDX_W-1:0]  round_idx_d;
  logic               msg_rd_d, w_sel_d, sel_res256_d, update_h_d, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    blk_d   = blk_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_INIT;
          first_d = first_block_i;
        end
      end
      S_INIT: begin
        if (first_q) blk_d = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (cnt_q == LAST_ROUND) begin
          cnt_d   = '0;
          state_d = S_FINAL;
        end else begin
          cnt_d = cnt_q + RIDX_W'(1);
        end
      end
      S_FINAL: begin
        blk_d   = blk_q + CNT_W'(1);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every transition and leaves the block count alone.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      first_d = first_q;
      blk_d   = blk_q;
    end
  end

  always_comb begin
    busy_d       = (state_d != S_IDLE);
    init_hash_d  = (state_d == S_INIT) && first_d;
    load_work_d  = (state_d == S_LOAD);
    round_en_d   = (state_d == S_ROUND);
    round_idx_d  = (state_d == S_ROUND) ? cnt_d : '0;
    msg_rd_d     = (state_d == S_ROUND) && (cnt_d < RAW_WORDS);
    w_sel_d      = (state_d == S_ROUND) && (cnt_d >= RAW_WORDS);
    sel_res256_d = (state_d == S_FINAL);
    update_h_d   = (state_d == S_FINAL);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      blk_q        <= '0;
      busy_o       <= 1'b0;
      init_hash_o  <= 1'b0;
      load_work_o  <= 1'b0;
      round_en_o   <= 1'b0;
      round_idx_o  <= '0;
      msg_rd_o     <= 1'b0;
      w_sel_o      <= 1'b0;
      sel_res256_o <= 1'b0;
      update_h_o   <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      blk_q        <= blk_d;
      busy_o       <= busy_d;
      init_hash_o  <= init_hash_d;
      load_work_o  <= load_work_d;
      round_en_o   <= round_en_d;
      round_idx_o  <= round_idx_d;
      msg_rd_o     <= msg_rd_d;
      w_sel_o      <= w_sel_d;
      sel_res256_o <= sel_res256_d;
      update_h_o   <= update_h_d;
      done_o       <= done_d;
    end
  end

  assign blk_cnt_o   = blk_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: per-cycle expected output vectors are queued
// when a block is launched and compared every cycle on the falling edge.
module tb_sha256_round_ctrl;

  localparam int RIDX_W = 6;
  localparam int CNT_W  = 2;
  localparam int VW     = 10 + RIDX_W + CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              first_block_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              busy_o, init_hash_o, load_work_o, round_en_o;
  logic [RIDX_W-1:0] round_idx_o;
  logic              msg_rd_o, w_sel_o, sel_res256_o, update_h_o, done_o;
  logic [CNT_W-1:0]  blk_cnt_o;
  logic [2:0]        dbg_state_o;

  sha256_round_ctrl #(.ROUNDS(64), .RIDX_W(RIDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .first_block_i(first_block_i),
    .abort_i(abort_i), .busy_o(busy_o), .init_hash_o(init_hash_o),
    .load_work_o(load_work_o), .round_en_o(round_en_o),
    .round_idx_o(round_idx_o), .msg_rd_o(msg_rd_o), .w_sel_o(w_sel_o),
    .sel_res256_o(sel_res256_o), .update_h_o(update_h_o), .done_o(done_o),
    .blk_cnt_o(blk_cnt_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] obs;
  int n_cmp = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] model_blk = '0;

  assign obs = {busy_o, init_hash_o, load_work_o, round_en_o, round_idx_o,
                msg_rd_o, w_sel_o, sel_res256_o, update_h_o, done_o, blk_cnt_o};

  function automatic logic [VW-1:0] mk(input logic busy, input logic init,
      input logic load, input logic ren, input int idx, input logic mrd,
      input logic wsel, input logic sel, input logic upd, input logic done,
      input logic [CNT_W-1:0] blk);
    logic [RIDX_W-1:0] i;
    i = RIDX_W'(idx);
    return {busy, init, load, ren, i, mrd, wsel, sel, upd, done, blk};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_pop(input string tag, input int k);
    logic [VW-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s k=%0d got=%h exp=<empty queue>", tag, k, obs);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s k=%0d", tag, k), obs, e);
    end
  endtask

  // Queue the cycle-by-cycle response of one block, launch it, compare it.
  // abort_k: cycle during which abort_i is high (0 = none).
  // es1/es2: cycles with a stray start_i pulse; stop_k: stop stepping early.
  task automatic run_block(input string tag, input logic first,
                           input logic abort_with_start, input int abort_k,
                           input int es1, input int es2, input int stop_k);
    logic [CNT_W-1:0] b1, b2, b3, blk_k;
    int last_k;
    b1 = model_blk;
    b2 = first ? '0 : b1;
    b3 = b2 + CNT_W'(1);
    last_k = (abort_k > 0) ? abort_k + 2 : 70;
    for (int k = 1; k <= last_k; k++) begin
      if (abort_k > 0 && k > abort_k) begin
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0, blk_k));
      end else if (k == 1) begin
        exp_q.push_back(mk(1, first,0,0,0,0,0,0,0,0, b1));
        blk_k = b1;
      end else if (k == 2) begin
        exp_q.push_back(mk(1,0,1,0,0,0,0,0,0,0, b2));
        blk_k = b2;
      end else if (k <= 66) begin
        exp_q.push_back(mk(1,0,0,1, k-3, (k-3) < 16, (k-3) >= 16, 0,0,0, b2));
        blk_k = b2;
      end else if (k == 67) begin
        exp_q.push_back(mk(1,0,0,0,0,0,0,1,1,0, b2));
        blk_k = b2;
      end else if (k == 68) begin
        exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,1, b3));
        blk_k = b3;
      end else begin
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0, b3));
        blk_k = b3;
      end
    end
    model_blk = (abort_k > 0) ? blk_k : b3;

    @(negedge clk);
    start_i = 1'b1;
    first_block_i = first;
    abort_i = abort_with_start;
    for (int k = 1; k <= last_k; k++) begin
      if (stop_k > 0 && k > stop_k) break;
      @(negedge clk);
      check_pop(tag, k);
      start_i = (k == es1) || (k == es2);
      first_block_i = $urandom_range(0, 1);
      abort_i = (k == abort_k);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    first_block_i = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    check("reset_outputs", obs, '0);
    repeat (2) @(negedge clk);
    check("reset_held", obs, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", obs, '0);

    // single first block
    run_block("first_blk", 1'b1, 1'b0, 0, 0, 0, 0);
    // chained blocks: count 2, 3
    run_block("chain1", 1'b0, 1'b0, 0, 0, 0, 0);
    run_block("chain2", 1'b0, 1'b0, 0, 0, 0, 0);
    // new first block clears then counts to 1
    run_block("new_first", 1'b1, 1'b0, 0, 0, 0, 0);
    // stray starts at idx 10 and in DONE are ignored
    run_block("start_busy", 1'b0, 1'b0, 0, 13, 68, 0);
    // abort at idx 40, then a full block
    run_block("abort40", 1'b0, 1'b0, 43, 0, 0, 0);
    run_block("after_abort", 1'b0, 1'b0, 0, 0, 0, 0);
    // abort together with start in IDLE: start wins
    run_block("start_abort_idle", 1'b0, 1'b1, 0, 0, 0, 0);
    // counter wrap with CNT_W=2: 1,2,3,0,1
    run_block("wrap1", 1'b1, 1'b0, 0, 0, 0, 0);
    run_block("wrap2", 1'b0, 1'b0, 0, 0, 0, 0);
    run_block("wrap3", 1'b0, 1'b0, 0, 0, 0, 0);
    run_block("wrap4", 1'b0, 1'b0, 0, 0, 0, 0);
    run_block("wrap5", 1'b0, 1'b0, 0, 0, 0, 0);

    // async reset at idx 20, between edges
    run_block("pre_reset", 1'b0, 1'b0, 0, 0, 0, 23);
    exp_q.delete();
    #2 rst = 1'b1;
    #1 check("async_reset_now", obs, '0);
    @(negedge clk);
    check("reset_no_done", obs, '0);
    rst = 1'b0;
    model_blk = '0;
    @(negedge clk);
    check("idle_after_midreset", obs, '0);
    run_block("post_reset", 1'b0, 1'b0, 0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL leftover_queue got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
